// File: rtl/spi_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_ram
// Brief    : Serial (SPI-style) command front end to a word RAM, with
//            optional auto-incrementing streaming read/write bursts.
// Revision : 1.0
// ============================================================================
module spi_burst_ram #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter int AUTO_INC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic wr_done,
    output logic frame_err
);

    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_FLD_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int c_BIT_W = $clog2(c_FLD_W + 1);
    localparam int c_N_MAX = c_FLD_W + 2;
    localparam int c_N_W   = $clog2(c_N_MAX + 1);

    localparam logic [c_BIT_W-1:0] c_ADDR_LAST    = c_BIT_W'(ADDR_W - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_LAST    = c_BIT_W'(DATA_W - 1);
    localparam logic [c_BIT_W-1:0] c_DATA_PRELAST = c_BIT_W'(DATA_W - 2);
    localparam logic [c_N_W-1:0]   c_N_SAT        = c_N_W'(c_N_MAX);
    localparam logic [c_N_W-1:0]   c_ADDR_END     = c_N_W'(ADDR_W + 2);
    localparam logic [c_N_W-1:0]   c_WR_END       = c_N_W'(DATA_W + 2);
    localparam logic [c_N_W-1:0]   c_RD_END       = c_N_W'(DATA_W + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_WR_ADDR = 3'd2,
        S_WR_DATA = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_DATA = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [c_DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [c_N_W-1:0]    r_n;
    logic [c_BIT_W-1:0]  r_bit;
    logic [c_FLD_W-2:0]  r_sh_in;
    logic [DATA_W-1:0]   r_sh_out;
    logic                r_cmd1;
    logic                r_armed;
    logic                r_miso;
    logic                r_wr_done;
    logic                r_frame_err;

    logic [c_FLD_W-1:0]  w_shift;
    logic [DATA_W-1:0]   w_rd_word;
    logic                w_wr_en;
    logic                w_wr_ptr_ld;
    logic                w_rd_ptr_ld;
    logic                w_rd_load;
    logic                w_rd_shift;
    logic                w_rd_inc;
    logic                w_bit_clr;
    logic                w_err;

    assign w_shift   = {r_sh_in, MOSI};
    assign w_rd_word = r_mem[r_rd_ptr];
    assign MISO      = r_miso;
    assign wr_done   = r_wr_done;
    assign frame_err = r_frame_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_wr_ptr_ld = 1'b0;
        w_rd_ptr_ld = 1'b0;
        w_rd_load   = 1'b0;
        w_rd_shift  = 1'b0;
        w_rd_inc    = 1'b0;
        w_bit_clr   = 1'b0;
        w_err       = 1'b0;
        if (SS_n) begin
            w_state_nxt = S_IDLE;
            // n still holds the low-edge count of the frame being closed
            case (r_state)
                S_CMD:                w_err = 1'b1;
                S_WR_ADDR, S_RD_ADDR: w_err = (r_n < c_ADDR_END);
                S_WR_DATA:            w_err = (r_n < c_WR_END);
                S_RD_DATA:            w_err = (r_n < c_RD_END);
                default:              w_err = 1'b0;
            endcase
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_armed) w_state_nxt = S_CMD;
                end
                S_CMD: begin
                    w_bit_clr = 1'b1;
                    case ({r_cmd1, MOSI})
                        2'b00:   w_state_nxt = S_WR_ADDR;
                        2'b01:   w_state_nxt = S_WR_DATA;
                        2'b10:   w_state_nxt = S_RD_ADDR;
                        default: begin
                            w_state_nxt = S_RD_DATA;
                            w_rd_load   = 1'b1;
                            w_rd_inc    = (AUTO_INC != 0) && (DATA_W == 1);
                        end
                    endcase
                end
                S_WR_ADDR, S_RD_ADDR: begin
                    if (r_bit == c_ADDR_LAST) begin
                        w_state_nxt = S_DONE;
                        w_wr_ptr_ld = (r_state == S_WR_ADDR);
                        w_rd_ptr_ld = (r_state == S_RD_ADDR);
                    end
                end
                S_WR_DATA: begin
                    if (r_bit == c_DATA_LAST) begin
                        w_wr_en   = 1'b1;
                        w_bit_clr = 1'b1;
                        if (AUTO_INC == 0) w_state_nxt = S_DONE;
                    end
                end
                S_RD_DATA: begin
                    // LSB is already on MISO: either reload the next word or stop
                    if (r_bit == c_DATA_LAST) begin
                        if (AUTO_INC != 0) begin
                            w_rd_load = 1'b1;
                            w_rd_inc  = (DATA_W == 1);
                        end else begin
                            w_state_nxt = S_DONE;
                        end
                    end else begin
                        w_rd_shift = 1'b1;
                        w_rd_inc   = (AUTO_INC != 0) && (r_bit == c_DATA_PRELAST);
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= '0;
            r_bit       <= '0;
            r_sh_in     <= '0;
            r_sh_out    <= '0;
            r_cmd1      <= 1'b0;
            r_armed     <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_miso      <= 1'b0;
            r_wr_done   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_wr_done   <= w_wr_en;
            r_frame_err <= w_err;
            r_sh_in     <= w_shift[c_FLD_W-2:0];
            r_bit       <= (w_bit_clr || w_rd_load) ? '0 : r_bit + 1'b1;
            // a frame is only recognised once SS_n has been seen high
            if (SS_n) r_armed <= 1'b1;
            if (r_state == S_IDLE) r_cmd1 <= MOSI;

            if (SS_n) begin
                r_n <= '0;
            end else if (r_state == S_IDLE) begin
                r_n <= {{(c_N_W-1){1'b0}}, r_armed};
            end else if (r_n != c_N_SAT) begin
                r_n <= r_n + 1'b1;
            end

            if (w_wr_ptr_ld) begin
                r_wr_ptr <= w_shift[ADDR_W-1:0];
            end else if (w_wr_en && (AUTO_INC != 0)) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_rd_ptr_ld) begin
                r_rd_ptr <= w_shift[ADDR_W-1:0];
            end else if (w_rd_inc) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_rd_load) begin
                r_miso   <= w_rd_word[DATA_W-1];
                r_sh_out <= w_rd_word << 1;
            end else if (w_rd_shift) begin
                r_miso   <= r_sh_out[DATA_W-1];
                r_sh_out <= r_sh_out << 1;
            end else if (w_state_nxt != S_RD_DATA) begin
                r_miso   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr_en) begin
            r_mem[r_wr_ptr] <= w_shift[DATA_W-1:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ram.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_ram
// Brief    : Randomised scoreboard bench for spi_burst_ram; instance 0 uses
//            default parameters, instance 1 uses 16-bit words, 4-bit address,
//            no auto-increment.
// Revision : 1.0
// ============================================================================
module tb_spi_burst_ram;

    typedef struct {
        int   u;
        int   cyc;
        logic v;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] ss_n = 2'b11;
    logic [1:0] mosi = 2'b00;
    logic [1:0] miso;
    logic [1:0] wr_done;
    logic [1:0] ferr;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic mon_en = 1'b0;

    ev_t  q_miso[$];
    ev_t  q_wr[$];
    ev_t  q_err[$];
    bit   tx[$];

    logic [15:0] mem_m [2][256];
    int          wr_ptr_m [2];
    int          rd_ptr_m [2];

    spi_burst_ram u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .MOSI     (mosi[0]),
        .SS_n     (ss_n[0]),
        .MISO     (miso[0]),
        .wr_done  (wr_done[0]),
        .frame_err(ferr[0])
    );

    spi_burst_ram #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(0)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .MOSI     (mosi[1]),
        .SS_n     (ss_n[1]),
        .MISO     (miso[1]),
        .wr_done  (wr_done[1]),
        .frame_err(ferr[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dw_of(input int u);
        return (u == 0) ? 8 : 16;
    endfunction

    function automatic int aw_of(input int u);
        return (u == 0) ? 8 : 4;
    endfunction

    task automatic chk(input string name, input int u, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s dut%0d cyc=%0d: got %0h expected %0h", name, u, cyc, act, exp);
        end
    endtask

    task automatic drive(input int u, input logic s, input logic m);
        @(negedge clk);
        ss_n[u] = s;
        mosi[u] = m;
    endtask

    task automatic push_word(input int val, input int w);
        for (int i = w - 1; i >= 0; i--) tx.push_back(bit'((val >> i) & 1));
    endtask

    // One frame: cmd, then len field bits (reads: len bits presented on MISO).
    // len < 0 closes the frame right after the first command bit.
    task automatic run_frame(input int u, input int cmd, input int len);
        int  dw, aw, dep, acc, words, base;
        bit  b;
        logic err;
        dw    = dw_of(u);
        aw    = aw_of(u);
        dep   = 1 << aw;
        acc   = 0;
        words = 0;
        err   = 1'b0;
        drive(u, 1'b0, 1'(cmd >> 1));
        if (len < 0) begin
            err = 1'b1;
        end else begin
            drive(u, 1'b0, 1'(cmd));
            if (cmd == 3) begin
                base = rd_ptr_m[u];
                for (int j = 0; j < len; j++) begin
                    if (j > 0) drive(u, 1'b0, 1'($urandom));
                    if (u == 0 || j < dw)
                        q_miso.push_back('{u, cyc + 1,
                            1'((mem_m[u][(base + j / dw) % dep] >> (dw - 1 - j % dw)) & 1)});
                end
                if (u == 0) rd_ptr_m[u] = (base + len / dw) % dep;
                err = (len < dw);
            end else begin
                for (int j = 0; j < len; j++) begin
                    b = (tx.size() > 0) ? tx.pop_front() : bit'($urandom);
                    drive(u, 1'b0, b);
                    acc = ((acc << 1) | int'(b)) & ((1 << dw) - 1);
                    if (cmd == 1 && (j + 1) % dw == 0 && (u == 0 || words == 0)) begin
                        mem_m[u][wr_ptr_m[u]] = 16'(acc);
                        q_wr.push_back('{u, cyc + 1, 1'b1});
                        if (u == 0) wr_ptr_m[u] = (wr_ptr_m[u] + 1) % dep;
                        words++;
                    end
                    if (cmd == 0 && j == aw - 1) wr_ptr_m[u] = acc & (dep - 1);
                    if (cmd == 2 && j == aw - 1) rd_ptr_m[u] = acc & (dep - 1);
                end
                err = (cmd == 1) ? (len < dw) : (len < aw);
            end
        end
        drive(u, 1'b1, 1'($urandom));
        if (err) q_err.push_back('{u, cyc + 1, 1'b1});
        drive(u, 1'b1, 1'b0);
        tx.delete();
    endtask

    task automatic wr_addr(input int u, input int a);
        push_word(a, aw_of(u));
        run_frame(u, 0, aw_of(u));
    endtask

    task automatic rd_addr(input int u, input int a);
        push_word(a, aw_of(u));
        run_frame(u, 2, aw_of(u));
    endtask

    task automatic wr_data(input int u, input int val);
        push_word(val, dw_of(u));
        run_frame(u, 1, dw_of(u));
    endtask

    // Scoreboard monitor: every cycle each output of each instance is
    // compared with the expectation queued for that cycle (absent = 0).
    initial begin : g_monitor
        ev_t  e;
        logic em, ew, ee;
        wait (mon_en);
        forever begin
            @(posedge clk);
            #1;
            for (int u = 0; u < 2; u++) begin
                em = 1'b0;
                ew = 1'b0;
                ee = 1'b0;
                if (q_miso.size() > 0 && q_miso[0].u == u && q_miso[0].cyc == cyc) begin
                    e = q_miso.pop_front();
                    em = e.v;
                end
                if (q_wr.size() > 0 && q_wr[0].u == u && q_wr[0].cyc == cyc) begin
                    e = q_wr.pop_front();
                    ew = e.v;
                end
                if (q_err.size() > 0 && q_err[0].u == u && q_err[0].cyc == cyc) begin
                    e = q_err.pop_front();
                    ee = e.v;
                end
                chk("miso", u, int'(miso[u]), int'(em));
                chk("wr_done", u, int'(wr_done[u]), int'(ew));
                chk("frame_err", u, int'(ferr[u]), int'(ee));
            end
        end
    end

    initial begin : g_watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : g_stim
        int u, cmd, len, start;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_m[i] = 0;
            rd_ptr_m[i] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Fill both memories so every later read has a known value
        start = $urandom_range(0, 255);
        wr_addr(0, start);
        for (int i = 0; i < 256; i++) push_word($urandom_range(0, 255), 8);
        run_frame(0, 1, 256 * 8);
        for (int a = 0; a < 16; a++) begin
            wr_addr(1, a);
            wr_data(1, $urandom_range(0, 65535));
        end

        // Single word write and read back
        wr_addr(0, 100);
        wr_data(0, 11);
        rd_addr(0, 100);
        run_frame(0, 3, 8);

        // Streaming write across the wrap, then streaming read
        wr_addr(0, 255);
        push_word(22, 8);
        push_word(33, 8);
        push_word(44, 8);
        run_frame(0, 1, 24);
        rd_addr(0, 255);
        run_frame(0, 3, 24);
        run_frame(0, 3, 8);

        // Partial data field: nothing written, pointer kept
        wr_addr(0, 37);
        run_frame(0, 1, 5);
        wr_data(0, 8'hA5);
        rd_addr(0, 37);
        run_frame(0, 3, 16);

        // Other partial fields
        run_frame(0, 0, 3);
        run_frame(0, 2, 0);
        run_frame(0, 3, 4);
        run_frame(0, 1, -1);
        run_frame(1, 3, 10);

        // Reset in the middle of a write frame
        drive(0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1);
        for (int j = 0; j < 3; j++) drive(0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wr_ptr_m[i] = 0;
            rd_ptr_m[i] = 0;
        end
        drive(0, 1'b0, 1'b0);
        drive(0, 1'b0, 1'b1);
        for (int j = 0; j < 8; j++) drive(0, 1'b0, 1'b1);
        drive(0, 1'b1, 1'b0);
        drive(0, 1'b1, 1'b0);
        run_frame(0, 3, 8);
        rd_addr(0, 100);
        run_frame(0, 3, 8);

        // Wide, non-incrementing instance
        wr_addr(1, 15);
        wr_data(1, 16'hBEEF);
        rd_addr(1, 15);
        run_frame(1, 3, 16);
        push_word(16'h1234, 16);
        push_word(16'h5678, 16);
        run_frame(1, 1, 32);
        run_frame(1, 3, 20);

        // Random frames on both instances
        for (int i = 0; i < 40; i++) begin
            u   = $urandom_range(0, 1);
            cmd = $urandom_range(0, 3);
            case (cmd)
                0, 2:    len = $urandom_range(0, aw_of(u) + 3);
                1:       len = $urandom_range(0, 3 * dw_of(u) + 3);
                default: len = $urandom_range(1, 3 * dw_of(u) + 2);
            endcase
            if ($urandom_range(0, 9) == 0) len = -1;
            run_frame(u, cmd, len);
            if (cmd != 3 && $urandom_range(0, 1) == 1) run_frame(u, 3, dw_of(u));
        end

        repeat (4) @(negedge clk);
        chk("miso_left", 0, q_miso.size(), 0);
        chk("wr_done_left", 0, q_wr.size(), 0);
        chk("frame_err_left", 0, q_err.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
